// File: rtl/mac_stream_pkg.sv
// rtl/mac_stream_pkg.sv - shared types and widths for the MAC stream driver
//
// Purpose: operand/accumulator widths, FSM state encoding and the
//          expected-result entry carried by the in-order result queue.
// Ports:   none (package).

package mac_stream_pkg;

  localparam int W_IN  = 8;   // signed operand width
  localparam int W_ACC = 16;  // signed accumulator/result width, wraps

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic signed [W_ACC-1:0] f;
    logic                    ovf;
  } exp_entry_t;

endpackage

// File: rtl/mac_stream_driver_sync_fifo.sv
// rtl/mac_stream_driver_sync_fifo.sv - show-ahead synchronous FIFO with flush
//
// Purpose: single-clock FIFO used for operand pairs and expected results.
//          Head entry is visible on o_head whenever o_count != 0.
// Ports:   clk, reset     clock, synchronous active-high reset
//          i_flush        drop all contents (dominates push/pop)
//          i_push         write i_push_data (ignored when full)
//          i_push_data    WIDTH-bit entry
//          i_pop          consume the head entry (ignored when empty)
//          o_head         current head entry
//          o_count        number of stored entries, 0..DEPTH

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_flush,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_push_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_head,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push && (r_count != DEPTH_C);
  assign w_do_pop  = i_pop && (r_count != '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage needs no reset: r_count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mac_stream_driver.sv
// rtl/mac_stream_driver.sv - MAC initiator with golden accumulator and in-order checker
//
// Purpose: buffers operand pairs, streams them into a MAC with a programmable
//          idle-slot pattern, predicts every result (wrapping sum plus sticky
//          overflow) and compares returned results strictly in order.
// Ports:   clk, reset                 clock, synchronous active-high reset
//          i_wr_en, i_wr_a, i_wr_b    operand pair load (IDLE/DONE only)
//          i_gap_mask                 bit i set -> issue slot i (mod 8) idles
//          i_start                    one-cycle run request
//          o_mac_reset                one-cycle MAC accumulator clear
//          o_a, o_b, o_valid_in       MAC operand stream
//          i_valid_out, i_f, i_overflow  MAC result stream
//          o_busy, o_done, o_pass, o_timeout   run status
//          o_load_drop                sticky: a write was refused
//          o_mismatch_count           saturating mismatch count
//          o_err_index                result index of first mismatch

module mac_stream_driver
  import mac_stream_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [W_IN-1:0]  i_wr_a,
  input  logic [W_IN-1:0]  i_wr_b,
  input  logic [7:0]       i_gap_mask,
  input  logic             i_start,
  output logic             o_mac_reset,
  output logic [W_IN-1:0]  o_a,
  output logic [W_IN-1:0]  o_b,
  output logic             o_valid_in,
  input  logic             i_valid_out,
  input  logic [W_ACC-1:0] i_f,
  input  logic             i_overflow,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_timeout,
  output logic             o_load_drop,
  output logic [7:0]       o_mismatch_count,
  output logic [7:0]       o_err_index
);

  localparam int OCW = $clog2(DEPTH+1);
  localparam int ECW = $clog2(MAX_OUT+1);
  localparam int TW  = $clog2(TIMEOUT+1);
  localparam logic [OCW-1:0] DEPTH_C   = OCW'(DEPTH);
  localparam logic [ECW-1:0] MAX_OUT_C = ECW'(MAX_OUT);
  localparam logic [TW-1:0]  TLIMIT    = TW'(TIMEOUT - 1);

  state_t                   r_state;
  logic                     r_mac_reset;
  logic [W_IN-1:0]          r_a;
  logic [W_IN-1:0]          r_b;
  logic                     r_valid_in;
  logic                     r_done;
  logic                     r_timeout;
  logic                     r_load_drop;
  logic [7:0]               r_mis;
  logic [7:0]               r_err_index;
  logic [7:0]               r_res_idx;
  logic [2:0]               r_gidx;
  logic [TW-1:0]            r_timer;
  logic signed [W_ACC-1:0]  r_exp_acc;
  logic                     r_exp_ovf;

  logic [2*W_IN-1:0]        w_op_head;
  logic [OCW-1:0]           w_op_count;
  logic [$bits(exp_entry_t)-1:0] w_exp_head_bits;
  exp_entry_t               w_exp_head;
  exp_entry_t               w_exp_in;
  logic [ECW-1:0]           w_exp_count;
  logic                     w_op_empty;
  logic                     w_exp_empty;
  logic                     w_wr_ok;
  logic                     w_checking;
  logic                     w_res_valid;
  logic                     w_exp_pop;
  logic                     w_mis;
  logic                     w_timer_clr;
  logic                     w_timeout_hit;
  logic                     w_issue;
  logic                     w_exp_flush;
  logic signed [2*W_IN-1:0] w_prod;
  logic signed [W_ACC-1:0]  w_p;
  logic signed [W_ACC-1:0]  w_s;
  logic                     w_ovf;

  assign w_op_empty  = (w_op_count == '0);
  assign w_exp_empty = (w_exp_count == '0);
  assign w_exp_head  = w_exp_head_bits;

  assign w_wr_ok = i_wr_en && (r_state == IDLE || r_state == DONE) &&
                   (w_op_count != DEPTH_C);

  // Result checking and the watchdog only run while results can be owed.
  assign w_checking    = (r_state == ISSUE) || (r_state == DRAIN);
  assign w_res_valid   = w_checking && i_valid_out;
  assign w_exp_pop     = w_res_valid && !w_exp_empty;
  assign w_mis         = w_res_valid && (w_exp_empty ||
                         (i_f != w_exp_head.f) || (i_overflow != w_exp_head.ovf));
  assign w_timer_clr   = i_valid_out || w_exp_empty;
  assign w_timeout_hit = w_checking && !w_timer_clr && (r_timer == TLIMIT);

  assign w_issue = (r_state == ISSUE) && !w_timeout_hit && !i_gap_mask[r_gidx] &&
                   (w_exp_count != MAX_OUT_C) && !w_op_empty;

  // Golden model of the MAC for the pair being issued this cycle.
  assign w_prod = $signed(w_op_head[2*W_IN-1:W_IN]) * $signed(w_op_head[W_IN-1:0]);
  assign w_p    = W_ACC'(w_prod);
  assign w_s    = r_exp_acc + w_p;
  assign w_ovf  = r_exp_ovf ||
                  ((w_p[W_ACC-1] == r_exp_acc[W_ACC-1]) && (w_s[W_ACC-1] != w_p[W_ACC-1]));

  assign w_exp_in.f   = w_s;
  assign w_exp_in.ovf = w_ovf;

  // An aborted run must leave nothing behind for the next one.
  assign w_exp_flush = w_timeout_hit || (r_state == CLR);

  sync_fifo #(
    .WIDTH (2*W_IN),
    .DEPTH (DEPTH)
  ) u_op_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (w_timeout_hit),
    .i_push      (w_wr_ok),
    .i_push_data ({i_wr_a, i_wr_b}),
    .i_pop       (w_issue),
    .o_head      (w_op_head),
    .o_count     (w_op_count)
  );

  sync_fifo #(
    .WIDTH ($bits(exp_entry_t)),
    .DEPTH (MAX_OUT)
  ) u_exp_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (w_exp_flush),
    .i_push      (w_issue),
    .i_push_data (w_exp_in),
    .i_pop       (w_exp_pop),
    .o_head      (w_exp_head_bits),
    .o_count     (w_exp_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mac_reset <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_valid_in  <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_load_drop <= 1'b0;
      r_mis       <= '0;
      r_err_index <= '0;
      r_res_idx   <= '0;
      r_gidx      <= '0;
      r_timer     <= '0;
      r_exp_acc   <= '0;
      r_exp_ovf   <= 1'b0;
    end else begin
      r_mac_reset <= 1'b0;
      r_valid_in  <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;

      if (i_wr_en && !w_wr_ok) begin
        r_load_drop <= 1'b1;
      end

      r_timer <= (!w_checking || w_timer_clr) ? '0 : r_timer + TW'(1);

      if (w_res_valid) begin
        r_res_idx <= r_res_idx + 8'd1;
        if (w_mis) begin
          if (r_mis == '0) begin
            r_err_index <= r_res_idx;
          end
          if (r_mis != 8'hFF) begin
            r_mis <= r_mis + 8'd1;
          end
        end
      end

      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state     <= CLR;
            r_mac_reset <= 1'b1;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_mis       <= '0;
            r_err_index <= '0;
            r_res_idx   <= '0;
          end
        end
        CLR: begin
          r_exp_acc <= '0;
          r_exp_ovf <= 1'b0;
          r_gidx    <= '0;
          if (w_op_empty) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          // Slot index advances on stalled and idle slots as well.
          r_gidx <= r_gidx + 3'd1;
          if (w_timeout_hit) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else if (w_issue) begin
            r_valid_in <= 1'b1;
            r_a        <= w_op_head[2*W_IN-1:W_IN];
            r_b        <= w_op_head[W_IN-1:0];
            r_exp_acc  <= w_s;
            r_exp_ovf  <= w_ovf;
            if (w_op_count == OCW'(1)) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_timeout_hit) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else if (w_exp_empty) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_mac_reset      = r_mac_reset;
  assign o_a              = r_a;
  assign o_b              = r_b;
  assign o_valid_in       = r_valid_in;
  assign o_busy           = (r_state == CLR) || (r_state == ISSUE) || (r_state == DRAIN);
  assign o_done           = r_done;
  assign o_pass           = r_done && (r_mis == '0) && !r_timeout;
  assign o_timeout        = r_timeout;
  assign o_load_drop      = r_load_drop;
  assign o_mismatch_count = r_mis;
  assign o_err_index      = r_err_index;

endmodule

// File: tb/tb_mac_stream_driver.sv
// tb/tb_mac_stream_driver.sv - self-checking bench for mac_stream_driver

module tb_mac_stream_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_wr_en;
  logic [7:0]  i_wr_a;
  logic [7:0]  i_wr_b;
  logic [7:0]  i_gap_mask;
  logic        i_start;
  logic        o_mac_reset;
  logic [7:0]  o_a;
  logic [7:0]  o_b;
  logic        o_valid_in;
  logic        i_valid_out;
  logic [15:0] i_f;
  logic        i_overflow;
  logic        o_busy;
  logic        o_done;
  logic        o_pass;
  logic        o_timeout;
  logic        o_load_drop;
  logic [7:0]  o_mismatch_count;
  logic [7:0]  o_err_index;

  always #5 clk = ~clk;

  mac_stream_driver dut (
    .clk              (clk),
    .reset            (reset),
    .i_wr_en          (i_wr_en),
    .i_wr_a           (i_wr_a),
    .i_wr_b           (i_wr_b),
    .i_gap_mask       (i_gap_mask),
    .i_start          (i_start),
    .o_mac_reset      (o_mac_reset),
    .o_a              (o_a),
    .o_b              (o_b),
    .o_valid_in       (o_valid_in),
    .i_valid_out      (i_valid_out),
    .i_f              (i_f),
    .i_overflow       (i_overflow),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_pass           (o_pass),
    .o_timeout        (o_timeout),
    .o_load_drop      (o_load_drop),
    .o_mismatch_count (o_mismatch_count),
    .o_err_index      (o_err_index)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural MAC: exact integer sum, wrapped to 16 bits, sticky overflow
  // whenever the exact step result leaves the signed 16-bit range.
  typedef struct {
    int f;
    bit ovf;
    int due;
  } res_t;

  res_t      m_q[$];
  int        m_acc;
  bit        m_ovf;
  int        m_ridx;
  int        m_p;
  int        m_t;
  res_t      m_r;
  int        cyc = 0;
  int        lat = 1;
  bit        silent = 0;
  int        fault_idx = -1;
  int        mr_cnt = 0;
  int        c0 = 0;
  int        last_wait = 0;
  bit        vin_q[$];
  bit [15:0] issued[$];
  bit [15:0] exp_pairs[$];
  int        res_log[$];
  bit        ovf_log[$];

  function automatic int wrap16(input int t);
    return int'(shortint'(t));
  endfunction

  task automatic mac_clear();
    m_q.delete();
    m_acc  = 0;
    m_ovf  = 0;
    m_ridx = 0;
  endtask

  initial begin
    i_valid_out = 1'b0;
    i_f         = '0;
    i_overflow  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      vin_q.push_back(o_valid_in);
      if (o_mac_reset) mr_cnt++;
      if (reset) begin
        mac_clear();
        i_valid_out = 1'b0;
        i_f         = '0;
        i_overflow  = 1'b0;
      end else begin
        if (o_mac_reset) begin
          mac_clear();
          c0 = vin_q.size() - 1;
          issued.delete();
          res_log.delete();
          ovf_log.delete();
        end
        if (o_valid_in) begin
          m_p = int'($signed(o_a)) * int'($signed(o_b));
          m_t = m_acc + m_p;
          if (m_t > 32767 || m_t < -32768) m_ovf = 1;
          m_acc = wrap16(m_t);
          m_q.push_back('{f: m_acc, ovf: m_ovf, due: cyc + lat});
          issued.push_back({o_a, o_b});
          res_log.push_back(m_acc);
          ovf_log.push_back(m_ovf);
        end
        if (!silent && m_q.size() > 0 && m_q[0].due <= cyc) begin
          m_r         = m_q.pop_front();
          i_valid_out = 1'b1;
          i_f         = 16'(m_r.f + ((m_ridx == fault_idx) ? 1 : 0));
          i_overflow  = m_r.ovf;
          m_ridx++;
        end else begin
          i_valid_out = 1'b0;
          i_f         = '0;
          i_overflow  = 1'b0;
        end
      end
    end
  end

  task automatic load(input bit [7:0] a, input bit [7:0] b, input bit accept);
    @(negedge clk);
    i_wr_en = 1'b1;
    i_wr_a  = a;
    i_wr_b  = b;
    if (accept) exp_pairs.push_back({a, b});
  endtask

  // same: assert start together with the last write; bw: try a write while busy.
  task automatic run(input string nm, input bit same, input bit bw,
                     input int exp_mis, input int exp_err, input bit exp_to);
    int w;
    mr_cnt = 0;
    if (!same) begin
      @(negedge clk);
      i_wr_en = 1'b0;
    end
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_wr_en = 1'b0;
    w = 0;
    while (!o_done && w < 600) begin
      if (bw && w == 0) begin
        i_wr_en = 1'b1;
        i_wr_a  = 8'h11;
        i_wr_b  = 8'h22;
      end else begin
        i_wr_en = 1'b0;
      end
      @(negedge clk);
      w++;
    end
    i_wr_en   = 1'b0;
    last_wait = w;
    check({nm, ":done"}, o_done, 1);
    check({nm, ":busy"}, o_busy, 0);
    check({nm, ":pass"}, o_pass, (!exp_to && exp_mis == 0) ? 1 : 0);
    check({nm, ":timeout"}, o_timeout, exp_to);
    check({nm, ":mismatch_count"}, o_mismatch_count, exp_mis);
    check({nm, ":err_index"}, o_err_index, exp_err);
    check({nm, ":mac_reset_cycles"}, mr_cnt, 1);
    if (!exp_to) begin
      check({nm, ":issued_count"}, issued.size(), exp_pairs.size());
      for (int i = 0; i < issued.size() && i < exp_pairs.size(); i++)
        check({nm, ":pair"}, issued[i], exp_pairs[i]);
    end
    exp_pairs.delete();
  endtask

  initial begin
    int n;
    int gap;
    int rem;
    bit exp_v;
    int fidx;

    reset      = 1'b1;
    i_wr_en    = 1'b0;
    i_wr_a     = '0;
    i_wr_b     = '0;
    i_gap_mask = '0;
    i_start    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst:busy", o_busy, 0);
    check("rst:done", o_done, 0);
    check("rst:pass", o_pass, 0);
    check("rst:valid_in", o_valid_in, 0);
    check("rst:mac_reset", o_mac_reset, 0);
    check("rst:load_drop", o_load_drop, 0);
    check("rst:mismatch_count", o_mismatch_count, 0);
    reset = 1'b0;

    // 1: two small pairs
    lat = 1;
    load(8'd2, 8'd2, 1);
    load(8'd3, 8'd3, 1);
    run("t1", 0, 0, 0, 0, 0);
    check("t1:results_n", res_log.size(), 2);
    if (res_log.size() == 2) begin
      check("t1:res0", res_log[0], 4);
      check("t1:res1", res_log[1], 13);
    end

    // 2: wrap and sticky overflow on the third result
    load(8'd100, 8'd120, 1);
    load(8'd100, 8'd120, 1);
    load(8'd100, 8'd120, 1);
    run("t2", 0, 0, 0, 0, 0);
    check("t2:results_n", res_log.size(), 3);
    if (res_log.size() == 3) begin
      check("t2:res0", res_log[0], 12000);
      check("t2:res1", res_log[1], 24000);
      check("t2:res2", res_log[2], -29536);
      check("t2:ovf1", ovf_log[1], 0);
      check("t2:ovf2", ovf_log[2], 1);
    end

    // 3: idle-slot pattern; slot k appears on valid_in two cycles after mac_reset + k
    i_gap_mask = 8'b0000_0101;
    for (int i = 0; i < 4; i++) load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
    run("t3", 0, 0, 0, 0, 0);
    rem = 4;
    for (int k = 0; k < 8; k++) begin
      exp_v = (rem > 0) && !i_gap_mask[k];
      if (exp_v) rem--;
      check("t3:valid_in_slot", vin_q[c0 + 2 + k], exp_v);
    end
    i_gap_mask = '0;

    // 4: faulty result at index 1
    fault_idx = 1;
    for (int i = 0; i < 3; i++) load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
    run("t4", 0, 0, 1, 1, 0);
    fault_idx = -1;

    // 5: MAC never answers
    silent = 1;
    load(8'd5, 8'd6, 1);
    load(8'd7, 8'd8, 1);
    run("t5", 0, 0, 0, 0, 1);
    check("t5:abort_window", (last_wait >= 60 && last_wait <= 72) ? 1 : 0, 1);
    silent = 0;

    // start with nothing loaded
    run("empty", 0, 0, 0, 0, 0);

    // write coinciding with start is part of the run
    load(8'd9, 8'd10, 1);
    load(8'hF6, 8'd3, 1);
    run("same_cycle", 1, 0, 0, 0, 0);

    // randomized runs with idle slots, latency and occasional fault
    for (int it = 0; it < 6; it++) begin
      n          = $urandom_range(1, 16);
      gap        = $urandom_range(0, 254);
      lat        = $urandom_range(1, 4);
      fidx       = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      fault_idx  = fidx;
      i_gap_mask = 8'(gap);
      for (int i = 0; i < n; i++)
        load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
      run("rnd", 0, 0, (fidx >= 0) ? 1 : 0, (fidx >= 0) ? fidx : 0, 0);
    end
    fault_idx  = -1;
    i_gap_mask = '0;
    lat        = 1;

    // write while busy is refused
    check("bw:load_drop_before", o_load_drop, 0);
    for (int i = 0; i < 3; i++) load(8'(i + 1), 8'(i + 2), 1);
    run("bw", 0, 1, 0, 0, 0);
    check("bw:load_drop_after", o_load_drop, 1);

    // 6: reset during ISSUE, then overfill
    lat = 3;
    for (int i = 0; i < 8; i++) load(8'(i + 20), 8'(i + 1), 1);
    @(negedge clk);
    i_wr_en = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6:busy_before_reset", o_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_pairs.delete();
    check("t6:busy", o_busy, 0);
    check("t6:done", o_done, 0);
    check("t6:valid_in", o_valid_in, 0);
    check("t6:a", o_a, 0);
    check("t6:b", o_b, 0);
    check("t6:timeout", o_timeout, 0);
    check("t6:load_drop", o_load_drop, 0);
    check("t6:mismatch_count", o_mismatch_count, 0);
    check("t6:err_index", o_err_index, 0);
    for (int i = 0; i < 16; i++) load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
    check("t6:load_drop_16", o_load_drop, 0);
    load(8'hAA, 8'hBB, 0);
    @(negedge clk);
    i_wr_en = 1'b0;
    check("t6:load_drop_17", o_load_drop, 1);
    run("t6", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
